// File: rtl/pic_prio_sched_if.sv
// pic_prio_sched_if
//   Groups the peripheral register bus and the CPU interrupt handshake
//   used by pic_prio_sched.
//   Bus     : DI[7:0] write data, DO[7:0] read data, addr[6:0],
//             CS (active low), nwe (write strobe), noe (read strobe)
//   Handshake: IREQ[7:0] masked requests, IACK acknowledge pulse,
//             nIRQ (active low request), VEC[2:0], VEC_VALID
//   master : CPU / controller side, slave : scheduler side.
interface pic_prio_sched_if;
  logic [7:0] DI;
  logic [7:0] DO;
  logic [6:0] addr;
  logic       CS;
  logic       nwe;
  logic       noe;
  logic [7:0] IREQ;
  logic       IACK;
  logic       nIRQ;
  logic [2:0] VEC;
  logic       VEC_VALID;

  modport master (
    output DI, addr, CS, nwe, noe, IREQ, IACK,
    input  DO, nIRQ, VEC, VEC_VALID
  );

  modport slave (
    input  DI, addr, CS, nwe, noe, IREQ, IACK,
    output DO, nIRQ, VEC, VEC_VALID
  );
endinterface

// File: rtl/pic_prio_sched.sv
// pic_prio_sched
//   Priority scheduler and acknowledge sequencer between the interrupt
//   controller's masked status vector and the CPU. Picks the best eligible
//   request (fixed or rotating priority), drives nIRQ, latches the vector
//   on IACK, tracks in-service sources for nesting and retires them on EOI.
//   Ports:
//     MCLK  : system clock, all state on the rising edge
//     RESET : synchronous active-high reset
//     bus   : pic_prio_sched_if.slave (register bus + IRQ handshake)
//   Registers: 0x00 CTRL, 0x01 ISR, 0x02 PEND, 0x03 EOI (wo),
//              0x04 CURVEC, 0x05 PTR.
//   Optional feature macro: PIC_SCHED_TIMEOUT_EN (request timeout, TOF flag).
module pic_prio_sched #(
  parameter int TIMEOUT = 255
) (
  input logic             MCLK,
  input logic             RESET,
  pic_prio_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACKD = 2'd2
  } state_t;

  // Terminal count: the request is withdrawn after TIMEOUT cycles in REQ.
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ctrl;
  logic [7:0] r_isr;
  logic [2:0] r_p;
  logic       r_spur;
  logic [2:0] r_w;
  logic       r_nirq;
  logic [2:0] r_vec;
  logic       r_vv;
  logic       w_tof;

  logic       w_nirq_nxt, w_vv_nxt, w_spur_set, w_tof_set, w_cnt_clr, w_cnt_inc;
  logic [2:0] w_vec_nxt, w_w_nxt;
  logic [7:0] w_isr_set, w_eoi_clr, w_base, w_pend, w_do;
  logic [3:0] w_isr_top, w_win;
  logic [2:0] w_top_rank, w_eoi_k;
  logic       w_eoi_hit, w_sel, w_wr, w_ctrl_wr, w_eoi_wr, w_en, w_rot;
  logic       w_unused;

  // Returns {found, index} of the set bit with the lowest rank (i - p) mod 8.
  function automatic logic [3:0] first_by_rank(input logic [7:0] vec, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    // Walk from the worst rank to the best so the best one is kept last.
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (vec[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_sel     = ~bus.CS;
  assign w_wr      = w_sel & bus.nwe;
  assign w_ctrl_wr = w_wr & (bus.addr == 7'h00);
  assign w_eoi_wr  = w_wr & (bus.addr == 7'h03);
  assign w_en      = r_ctrl[0];
  assign w_rot     = r_ctrl[1];

  assign w_isr_top  = first_by_rank(r_isr, r_p);
  assign w_top_rank = w_isr_top[2:0] - r_p;
  assign w_base     = bus.IREQ & ~r_isr & {8{w_en}};
  assign w_win      = first_by_rank(w_pend, r_p);

  // Eligibility: while something is in service, only strictly better ranks may nest.
  always_comb begin
    w_pend = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_pend[i] = w_base[i] & (~w_isr_top[3] | ((3'(i) - r_p) < w_top_rank));
    end
  end

  // EOI target: specific bit from DI, or the best-ranked in-service bit.
  always_comb begin
    w_eoi_clr = 8'h00;
    w_eoi_k   = 3'd0;
    w_eoi_hit = 1'b0;
    if (w_eoi_wr) begin
      if (bus.DI[7]) begin
        w_eoi_k   = bus.DI[2:0];
        w_eoi_hit = r_isr[bus.DI[2:0]];
      end else begin
        w_eoi_k   = w_isr_top[2:0];
        w_eoi_hit = w_isr_top[3];
      end
    end else begin
      w_eoi_hit = 1'b0;
    end
    if (w_eoi_hit) begin
      w_eoi_clr[w_eoi_k] = 1'b1;
    end else begin
      w_eoi_clr = 8'h00;
    end
  end

  // Request/acknowledge sequencer: next state and registered-output updates.
  always_comb begin
    w_state_nxt = r_state;
    w_nirq_nxt  = r_nirq;
    w_vec_nxt   = r_vec;
    w_vv_nxt    = r_vv;
    w_w_nxt     = r_w;
    w_isr_set   = 8'h00;
    w_spur_set  = 1'b0;
    w_tof_set   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win[3]) begin
          w_w_nxt     = w_win[2:0];
          w_nirq_nxt  = 1'b0;
          w_vv_nxt    = 1'b0;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        // W is held even if a better request shows up; it is only dropped.
        if (~bus.IREQ[r_w] | ~w_en | ~w_pend[r_w]) begin
          w_nirq_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
          if (bus.IACK) begin
            w_spur_set = 1'b1;
            w_vec_nxt  = 3'd7;
            w_vv_nxt   = 1'b1;
          end else begin
            w_spur_set = 1'b0;
          end
        end else if (bus.IACK) begin
          w_isr_set[r_w] = 1'b1;
          w_vec_nxt      = r_w;
          w_vv_nxt       = 1'b1;
          w_nirq_nxt     = 1'b1;
          w_state_nxt    = S_ACKD;
        end else begin
`ifdef PIC_SCHED_TIMEOUT_EN
          if (r_cnt == TO_LIM) begin
            w_nirq_nxt  = 1'b1;
            w_tof_set   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_inc = 1'b1;
          end
`else
          w_state_nxt = S_REQ;
`endif
        end
      end
      S_ACKD: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_nirq_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: control, in-service set, pointer, outputs.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_ctrl <= 2'b00;
      r_isr  <= 8'h00;
      r_p    <= 3'd0;
      r_spur <= 1'b0;
      r_w    <= 3'd0;
      r_nirq <= 1'b1;
      r_vec  <= 3'd0;
      r_vv   <= 1'b0;
    end else begin
      // Set is applied after clear so an IACK wins over an EOI to the same bit.
      r_isr  <= (r_isr & ~w_eoi_clr) | w_isr_set;
      r_w    <= w_w_nxt;
      r_nirq <= w_nirq_nxt;
      r_vec  <= w_vec_nxt;
      r_vv   <= w_vv_nxt;
      if (w_ctrl_wr) begin
        r_ctrl <= bus.DI[1:0];
      end
      if (w_spur_set) begin
        r_spur <= 1'b1;
      end else if (w_ctrl_wr & bus.DI[6]) begin
        r_spur <= 1'b0;
      end
      if (w_rot & w_eoi_hit) begin
        r_p <= w_eoi_k + 3'd1;
      end
    end
  end

`ifdef PIC_SCHED_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_tof;

  // Request timeout counter and sticky timeout flag.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_cnt <= 8'd0;
      r_tof <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= 8'd0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_tof_set) begin
        r_tof <= 1'b1;
      end else if (w_ctrl_wr & bus.DI[6]) begin
        r_tof <= 1'b0;
      end
    end
  end
  assign w_tof    = r_tof;
  assign w_unused = ^{bus.DI[5:3], w_cnt_clr};
`else
  assign w_tof    = 1'b0;
  assign w_unused = ^{bus.DI[5:3], TO_LIM, w_tof_set, w_cnt_clr, w_cnt_inc};
`endif

  // Combinational register read mux.
  always_comb begin
    w_do = 8'h00;
    if (w_sel & bus.noe) begin
      case (bus.addr)
        7'h00:   w_do = {w_tof, r_spur, 4'b0000, r_ctrl};
        7'h01:   w_do = r_isr;
        7'h02:   w_do = w_pend;
        7'h04:   w_do = {r_vv, r_spur, 3'b000, r_vec};
        7'h05:   w_do = {5'b00000, r_p};
        default: w_do = 8'h00;
      endcase
    end else begin
      w_do = 8'h00;
    end
  end

  assign bus.DO        = w_do;
  assign bus.nIRQ      = r_nirq;
  assign bus.VEC       = r_vec;
  assign bus.VEC_VALID = r_vv;

endmodule

// File: tb/tb_pic_prio_sched.sv
// tb_pic_prio_sched
//   Directed-vector bench for pic_prio_sched: fixed priority, nesting,
//   rotation, spurious acknowledge, reset and EOI corner cases, and the
//   optional timeout (PIC_SCHED_TIMEOUT_EN, TIMEOUT=4).
module tb_pic_prio_sched;
  logic MCLK;
  logic RESET;
  int   n_vec;
  int   n_err;
  logic [7:0] rd;

  pic_prio_sched_if bus_if ();

  pic_prio_sched #(.TIMEOUT(4)) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .bus   (bus_if)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic bus_wr(input logic [6:0] a, input logic [7:0] d);
    bus_if.CS   = 1'b0;
    bus_if.nwe  = 1'b1;
    bus_if.addr = a;
    bus_if.DI   = d;
    tick();
    bus_if.CS   = 1'b1;
    bus_if.nwe  = 1'b0;
    bus_if.DI   = 8'h00;
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
    bus_if.CS   = 1'b0;
    bus_if.noe  = 1'b1;
    bus_if.addr = a;
    #1;
    rd = bus_if.DO;
    bus_if.CS   = 1'b1;
    bus_if.noe  = 1'b0;
    check_val(tag, rd, exp);
  endtask

  task automatic iack();
    bus_if.IACK = 1'b1;
    tick();
    bus_if.IACK = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RESET = 1'b1;
    bus_if.DI = 8'h00; bus_if.addr = 7'h00; bus_if.CS = 1'b1;
    bus_if.nwe = 1'b0; bus_if.noe = 1'b0; bus_if.IREQ = 8'h00; bus_if.IACK = 1'b0;
    tick(); tick();
    RESET = 1'b0;

    // Reset state
    check_val("rst_nirq", {7'd0, bus_if.nIRQ}, 8'h01);
    check_val("rst_vec", {5'd0, bus_if.VEC}, 8'h00);
    check_val("rst_vv", {7'd0, bus_if.VEC_VALID}, 8'h00);
    rd_chk("rst_ctrl", 7'h00, 8'h00);
    rd_chk("rst_isr", 7'h01, 8'h00);
    rd_chk("rst_ptr", 7'h05, 8'h00);
    rd_chk("unmapped", 7'h33, 8'h00);

    // Fixed priority
    bus_wr(7'h00, 8'h01);
    bus_if.IREQ = 8'h28;
    #1;
    check_val("lat_pre", {7'd0, bus_if.nIRQ}, 8'h01);
    tick();
    check_val("lat_nirq", {7'd0, bus_if.nIRQ}, 8'h00);
    check_val("req_vv0", {7'd0, bus_if.VEC_VALID}, 8'h00);
    rd_chk("pend_28", 7'h02, 8'h28);
    iack();
    check_val("fix_vec", {5'd0, bus_if.VEC}, 8'h03);
    check_val("fix_nirq", {7'd0, bus_if.nIRQ}, 8'h01);
    rd_chk("fix_isr", 7'h01, 8'h08);
    rd_chk("fix_curvec", 7'h04, 8'h83);

    // Nesting
    tick(); tick();
    rd_chk("nest_pend0", 7'h02, 8'h00);
    check_val("nest_hold", {7'd0, bus_if.nIRQ}, 8'h01);
    bus_if.IREQ = 8'h2C;
    tick();
    check_val("nest_nirq", {7'd0, bus_if.nIRQ}, 8'h00);
    iack();
    bus_if.IREQ = 8'h00;
    check_val("nest_vec", {5'd0, bus_if.VEC}, 8'h02);
    rd_chk("nest_isr", 7'h01, 8'h0C);
    bus_wr(7'h03, 8'h00);
    rd_chk("nspec_eoi", 7'h01, 8'h08);
    bus_wr(7'h03, 8'h83);
    rd_chk("spec_eoi", 7'h01, 8'h00);
    rd_chk("fix_ptr", 7'h05, 8'h00);

    // W is not replaced by a better request while in REQ
    bus_if.IREQ = 8'h10;
    tick();
    bus_if.IREQ = 8'h11;
    tick();
    iack();
    bus_if.IREQ = 8'h00;
    check_val("hold_w", {5'd0, bus_if.VEC}, 8'h04);
    bus_wr(7'h03, 8'h84);

    // Rotation
    bus_wr(7'h00, 8'h03);
    bus_if.IREQ = 8'h20;
    tick();
    iack();
    bus_if.IREQ = 8'h00;
    check_val("rot_vec5", {5'd0, bus_if.VEC}, 8'h05);
    tick();
    bus_wr(7'h03, 8'h85);
    rd_chk("rot_ptr6", 7'h05, 8'h06);
    bus_if.IREQ = 8'h41;
    tick();
    iack();
    check_val("rot_vec6", {5'd0, bus_if.VEC}, 8'h06);
    rd_chk("rot_isr40", 7'h01, 8'h40);
    bus_wr(7'h03, 8'h86);
    tick();
    iack();
    bus_if.IREQ = 8'h00;
    check_val("rot_vec0", {5'd0, bus_if.VEC}, 8'h00);
    rd_chk("rot_ptr7", 7'h05, 8'h07);
    bus_wr(7'h03, 8'h00);
    rd_chk("rot_ptr1", 7'h05, 8'h01);
    bus_wr(7'h00, 8'h01);

    // Spurious acknowledge
    bus_if.IREQ = 8'h10;
    tick();
    check_val("spur_req", {7'd0, bus_if.nIRQ}, 8'h00);
    bus_if.IREQ = 8'h00;
    iack();
    check_val("spur_vec", {5'd0, bus_if.VEC}, 8'h07);
    check_val("spur_vv", {7'd0, bus_if.VEC_VALID}, 8'h01);
    check_val("spur_nirq", {7'd0, bus_if.nIRQ}, 8'h01);
    rd_chk("spur_isr", 7'h01, 8'h00);
    rd_chk("spur_ctrl", 7'h00, 8'h41);
    rd_chk("spur_curvec", 7'h04, 8'hC7);
    bus_wr(7'h00, 8'h41);
    rd_chk("spur_clr", 7'h00, 8'h01);

    // Reset during REQ with an in-service bit (P=1 here)
    bus_if.IREQ = 8'h08;
    tick();
    iack();
    bus_if.IREQ = 8'h0A;
    tick(); tick();
    check_val("pre_rst_req", {7'd0, bus_if.nIRQ}, 8'h00);
    RESET = 1'b1;
    tick();
    check_val("mid_rst_nirq", {7'd0, bus_if.nIRQ}, 8'h01);
    rd_chk("mid_rst_isr", 7'h01, 8'h00);
    rd_chk("mid_rst_ptr", 7'h05, 8'h00);
    RESET = 1'b0;
    bus_if.IREQ = 8'h00;

    // Non-specific EOI with nothing in service
    bus_wr(7'h00, 8'h03);
    bus_wr(7'h03, 8'h00);
    rd_chk("eoi_empty_isr", 7'h01, 8'h00);
    rd_chk("eoi_empty_ptr", 7'h05, 8'h00);

    // Simultaneous IACK and specific EOI to the same bit
    bus_wr(7'h00, 8'h01);
    bus_if.IREQ = 8'h02;
    tick();
    bus_if.CS = 1'b0; bus_if.nwe = 1'b1; bus_if.addr = 7'h03; bus_if.DI = 8'h81;
    iack();
    bus_if.CS = 1'b1; bus_if.nwe = 1'b0; bus_if.DI = 8'h00;
    bus_if.IREQ = 8'h00;
    rd_chk("sim_isr", 7'h01, 8'h02);
    check_val("sim_vec", {5'd0, bus_if.VEC}, 8'h01);
    bus_wr(7'h03, 8'h81);
    tick();

    // Timeout behaviour
    bus_if.IREQ = 8'h04;
    tick();
    check_val("to_enter", {7'd0, bus_if.nIRQ}, 8'h00);
    tick(); tick(); tick();
    check_val("to_hold3", {7'd0, bus_if.nIRQ}, 8'h00);
    tick();
`ifdef PIC_SCHED_TIMEOUT_EN
    check_val("to_exit", {7'd0, bus_if.nIRQ}, 8'h01);
    rd_chk("to_tof", 7'h00, 8'h81);
    tick();
    check_val("to_rereq", {7'd0, bus_if.nIRQ}, 8'h00);
    bus_wr(7'h00, 8'h41);
    rd_chk("to_tof_clr", 7'h00, 8'h01);
`else
    tick(); tick(); tick(); tick(); tick();
    check_val("no_to_hold", {7'd0, bus_if.nIRQ}, 8'h00);
    rd_chk("no_to_tof", 7'h00, 8'h01);
`endif
    bus_if.IREQ = 8'h00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
